// File: rtl/tsm_pkg.sv
// Shared constants and state encoding for the template scan matcher.
package tsm_pkg;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = 13;
    localparam logic FG_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tsm_state_e;

endpackage

// File: rtl/pix_score_acc.sv
// Three pixel-pair score accumulators; exposes next-state values so the
// owner can capture the final totals on the same edge as the last pixel.
module pix_score_acc
    import tsm_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             tmpl_bit_i,
    input  logic             img_bit_i,
    output logic [CNT_W-1:0] match_d_o,
    output logic [CNT_W-1:0] fg_hit_d_o,
    output logic [CNT_W-1:0] tmpl_fg_d_o
);

    logic [CNT_W-1:0] match_q, fg_hit_q, tmpl_fg_q;
    logic [CNT_W-1:0] match_d, fg_hit_d, tmpl_fg_d;
    logic             tmpl_fg, img_fg;

    always_comb begin
        tmpl_fg   = (tmpl_bit_i == FG_LEVEL);
        img_fg    = (img_bit_i == FG_LEVEL);
        match_d   = match_q   + CNT_W'(valid_i && (tmpl_bit_i == img_bit_i));
        fg_hit_d  = fg_hit_q  + CNT_W'(valid_i && tmpl_fg && img_fg);
        tmpl_fg_d = tmpl_fg_q + CNT_W'(valid_i && tmpl_fg);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            match_q   <= '0;
            fg_hit_q  <= '0;
            tmpl_fg_q <= '0;
        end else begin
            match_q   <= match_d;
            fg_hit_q  <= fg_hit_d;
            tmpl_fg_q <= tmpl_fg_d;
        end
    end

    assign match_d_o   = match_d;
    assign fg_hit_d_o  = fg_hit_d;
    assign tmpl_fg_d_o = tmpl_fg_d;

endmodule

// File: rtl/template_scan_matcher.sv
// Sweeps one template ROM and the image buffer in lockstep and scores the
// pixel pairs; results land in the DONE cycle, DEPTH+2 cycles after start.
module template_scan_matcher
    import tsm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic              rom_dout,
    output logic              img_ce,
    output logic [ADDR_W-1:0] img_ad,
    input  logic              img_dout,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  fg_hit_cnt,
    output logic [CNT_W-1:0]  tmpl_fg_cnt
);

    localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);

    tsm_state_e        state_q;
    logic              busy_q, done_q, ce_q, vld_q;
    logic [ADDR_W-1:0] ad_q;
    logic [CNT_W-1:0]  match_q, fg_hit_q, tmpl_fg_q;
    logic [CNT_W-1:0]  match_d, fg_hit_d, tmpl_fg_d;
    logic              acc_clear;

    assign acc_clear = (state_q == IDLE) && start && !abort;

    pix_score_acc u_acc (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (acc_clear),
        .valid_i     (vld_q),
        .tmpl_bit_i  (rom_dout),
        .img_bit_i   (img_dout),
        .match_d_o   (match_d),
        .fg_hit_d_o  (fg_hit_d),
        .tmpl_fg_d_o (tmpl_fg_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ce_q      <= 1'b0;
            vld_q     <= 1'b0;
            ad_q      <= '0;
            match_q   <= '0;
            fg_hit_q  <= '0;
            tmpl_fg_q <= '0;
        end else begin
            done_q <= 1'b0;
            // ROM data trails its address by one cycle
            vld_q  <= ce_q;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b1;
                        ad_q    <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ce_q    <= 1'b0;
                    end else if (ad_q == LAST_AD) begin
                        state_q <= DRAIN;
                        ce_q    <= 1'b0;
                    end else begin
                        ad_q <= ad_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    busy_q <= 1'b0;
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        // Capture totals including the last pixel accumulated this edge
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        match_q   <= match_d;
                        fg_hit_q  <= fg_hit_d;
                        tmpl_fg_q <= tmpl_fg_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ce_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rom_ce      = ce_q;
    assign img_ce      = ce_q;
    assign rom_oce     = busy_q;
    assign rom_ad      = ad_q;
    assign img_ad      = ad_q;
    assign match_cnt   = match_q;
    assign fg_hit_cnt  = fg_hit_q;
    assign tmpl_fg_cnt = tmpl_fg_q;

endmodule

// File: tb/tb_template_scan_matcher.sv
// Directed bench: behavioural ROM/image models with 1-cycle read latency.
module tb_template_scan_matcher;
    import tsm_pkg::*;

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic              rom_ce, rom_oce, img_ce, busy, done;
    logic [ADDR_W-1:0] rom_ad, img_ad;
    logic              rom_dout = 1'b0;
    logic              img_dout = 1'b0;
    logic [CNT_W-1:0]  match_cnt, fg_hit_cnt, tmpl_fg_cnt;

    logic tmpl_mem [0:4095];
    logic img_mem  [0:4095];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    template_scan_matcher dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .rom_ce      (rom_ce),
        .rom_oce     (rom_oce),
        .rom_ad      (rom_ad),
        .rom_dout    (rom_dout),
        .img_ce      (img_ce),
        .img_ad      (img_ad),
        .img_dout    (img_dout),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt),
        .fg_hit_cnt  (fg_hit_cnt),
        .tmpl_fg_cnt (tmpl_fg_cnt)
    );

    always @(posedge clk) begin
        if (rom_ce) rom_dout <= tmpl_mem[rom_ad];
        if (img_ce) img_dout <= img_mem[img_ad];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Digit 6 strokes on a 64x64 grid; hand count of stroke pixels is 1040.
    function automatic bit is_stroke(int a);
        int x, y;
        x = a % 64;
        y = a / 64;
        if (x >= 16 && x <= 23 && y >= 8 && y <= 55) return 1'b1;
        if (x >= 24 && x <= 47 && y >= 8 && y <= 15) return 1'b1;
        if (x >= 24 && x <= 47 && y >= 30 && y <= 37) return 1'b1;
        if (x >= 24 && x <= 47 && y >= 48 && y <= 55) return 1'b1;
        if (x >= 40 && x <= 47 && y >= 38 && y <= 47) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk_counts(input string tag, input int m, input int f, input int t);
        chk({tag, ".match"},   int'(match_cnt),   m);
        chk({tag, ".fg_hit"},  int'(fg_hit_cnt),  f);
        chk({tag, ".tmpl_fg"}, int'(tmpl_fg_cnt), t);
    endtask

    task automatic run_scan(input string tag, input int m, input int f, input int t);
        int cyc;
        bit seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_first"}, int'(busy), 1);
        chk({tag, ".ce_first"},   int'(rom_ce && img_ce), 1);
        chk({tag, ".ad_first"},   int'(rom_ad), 0);
        chk({tag, ".oce_first"},  int'(rom_oce), 1);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 4200) begin
            tick();
            cyc++;
            if (cyc == 4097) begin
                chk({tag, ".drain_ce"},   int'(rom_ce), 0);
                chk({tag, ".drain_ad"},   int'(img_ad), 4095);
                chk({tag, ".drain_busy"}, int'(busy), 1);
            end
            if (done) seen = 1'b1;
        end
        chk({tag, ".done_cycle"}, cyc, 4098);
        chk({tag, ".done_busy"},  int'(busy), 0);
        chk_counts(tag, m, f, t);
        tick();
        chk({tag, ".done_pulse"}, int'(done), 0);
        chk_counts({tag, ".hold"}, m, f, t);
    endtask

    initial begin
        int cyc;
        bit seen;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            tmpl_mem[i] = 1'b1;
            img_mem[i]  = 1'b1;
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.ce",   int'(rom_ce), 0);
        chk("rst.oce",  int'(rom_oce), 0);
        chk("rst.ad",   int'(rom_ad), 0);
        chk_counts("rst", 0, 0, 0);

        run_scan("s1", 4096, 0, 0);

        for (int i = 0; i < 4096; i++) begin
            tmpl_mem[i] = !is_stroke(i);
            img_mem[i]  = !is_stroke(i);
        end
        run_scan("s2", 4096, 1040, 1040);

        for (int i = 0; i < 4096; i++) img_mem[i] = is_stroke(i);
        run_scan("s3", 0, 0, 1040);

        for (int i = 0; i < 4096; i++) img_mem[i] = !is_stroke(i);
        img_mem[4095] = 1'b0;
        run_scan("s4", 4095, 1040, 1040);

        // Restart attempt mid-scan is ignored, then abort
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin tick(); cyc++; end
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc++;
        chk("s5.restart_ad",   int'(rom_ad), 100);
        chk("s5.restart_busy", int'(busy), 1);
        while (cyc < 2000) begin tick(); cyc++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s5.abort_busy", int'(busy), 0);
        chk("s5.abort_ce",   int'(rom_ce), 0);
        chk("s5.abort_oce",  int'(rom_oce), 0);
        seen = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        chk("s5.no_done", int'(seen), 0);
        chk_counts("s5.kept", 4095, 1040, 1040);

        img_mem[4095] = 1'b1;
        run_scan("s5b", 4096, 1040, 1040);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa.busy", int'(busy), 0);
        chk("sa.ce",   int'(rom_ce), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 500) begin tick(); cyc++; end
        reset = 1'b1;
        tick();
        chk("s6.busy", int'(busy), 0);
        chk("s6.ce",   int'(rom_ce), 0);
        chk("s6.ad",   int'(rom_ad), 0);
        chk("s6.oce",  int'(rom_oce), 0);
        chk_counts("s6", 0, 0, 0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("s6.no_done", int'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
